// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch request generator for the RV32I front end.
// Issues req/gnt fetches, applies trap/branch redirects and holds the address while a request is outstanding.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              INC          = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    output logic [XLEN-1:0] pc_o,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        FETCH      = 2'd1,
        REDIR_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            pend_trap_q, pend_trap_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] br_tgt;

    assign br_tgt = {br_target_i[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            pend_q      <= '0;
            pend_trap_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_trap_q <= pend_trap_d;
            misalign_q  <= misalign_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_trap_d = pend_trap_q;
        misalign_d  = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                // A redirect without a grant must not move the address of the live request.
                if (trap_i) begin
                    if (imem_gnt_i) begin
                        pc_d = TRAP_VECTOR;
                    end else begin
                        pend_d      = TRAP_VECTOR;
                        pend_trap_d = 1'b1;
                        state_d     = REDIR_WAIT;
                    end
                end else if (br_taken_i) begin
                    misalign_d = |br_target_i[1:0];
                    if (imem_gnt_i) begin
                        pc_d = br_tgt;
                    end else begin
                        pend_d      = br_tgt;
                        pend_trap_d = 1'b0;
                        state_d     = REDIR_WAIT;
                    end
                end else if (imem_gnt_i && !stall_i) begin
                    pc_d = pc_q + XLEN'(INC);
                end
            end
            REDIR_WAIT: begin
                // A pending trap outranks any later branch; the grant here only retires the stale fetch.
                if (trap_i) begin
                    if (imem_gnt_i) begin
                        pc_d        = TRAP_VECTOR;
                        pend_trap_d = 1'b0;
                        state_d     = FETCH;
                    end else begin
                        pend_d      = TRAP_VECTOR;
                        pend_trap_d = 1'b1;
                    end
                end else if (br_taken_i && !pend_trap_q) begin
                    misalign_d = |br_target_i[1:0];
                    if (imem_gnt_i) begin
                        pc_d    = br_tgt;
                        state_d = FETCH;
                    end else begin
                        pend_d = br_tgt;
                    end
                end else if (imem_gnt_i) begin
                    pc_d        = pend_q;
                    pend_trap_d = 1'b0;
                    state_d     = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_req_o  = (state_q != BOOT);
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign if_pc_o     = pc_q;
    assign misalign_o  = misalign_q;
    assign if_valid_o  = imem_gnt_i & imem_req_o & !stall_i & !trap_i & !br_taken_i
                         & (state_q == FETCH);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit: sequential fetch, grant stalls, redirects, traps, wrap and reset.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        trap_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic [31:0] pc_o;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic        misalign_o;

    int checks;
    int failures;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .trap_i      (trap_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_gnt_i  (imem_gnt_i),
        .pc_o        (pc_o),
        .if_valid_o  (if_valid_o),
        .if_pc_o     (if_pc_o),
        .misalign_o  (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i     = 1'b0;
        br_taken_i  = 1'b0;
        br_target_i = '0;
        trap_i      = 1'b0;
        imem_gnt_i  = 1'b0;
    endtask

    // Reset, release, and clock once through BOOT so the unit is in FETCH at pc 0.
    task automatic reset_to_fetch();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        imem_gnt_i = 1'b1;
        rst = 1'b0;
        step();
        step();
        checks++;
        if (imem_req_o !== 1'b0 || pc_o !== 32'h0 || if_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: req=%b pc=%h valid=%b mis=%b, want req=0 pc=0 valid=0 mis=0",
                     imem_req_o, pc_o, if_valid_o, misalign_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL boot_no_req: req=%b want 0", imem_req_o);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        step();
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            checks++;
            if (imem_req_o !== 1'b1 || pc_o !== exp_pc || imem_addr_o !== exp_pc
                || if_pc_o !== exp_pc || if_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL seq_fetch[%0d]: req=%b pc=%h addr=%h ifpc=%h valid=%b, want req=1 pc=addr=%h valid=1",
                         i, imem_req_o, pc_o, imem_addr_o, if_pc_o, if_valid_o, exp_pc);
            end
            step();
        end
    endtask

    task automatic test_gnt_wait();
        reset_to_fetch();
        imem_gnt_i = 1'b1;
        step();
        step();
        imem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (pc_o !== 32'h8 || imem_addr_o !== 32'h8 || imem_req_o !== 1'b1 || if_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL gnt_low_hold[%0d]: pc=%h addr=%h req=%b valid=%b, want pc=addr=8 req=1 valid=0",
                         i, pc_o, imem_addr_o, imem_req_o, if_valid_o);
            end
            stall_i = (i == 1);
            step();
        end
        stall_i    = 1'b0;
        imem_gnt_i = 1'b1;
        #1;
        checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8) begin
            failures++;
            $display("FAIL gnt_arrive_valid: valid=%b ifpc=%h, want valid=1 ifpc=8", if_valid_o, if_pc_o);
        end
        step();
        checks++;
        if (pc_o !== 32'hC) begin
            failures++;
            $display("FAIL gnt_advance: pc=%h want 0000000c", pc_o);
        end
    endtask

    task automatic test_branch();
        imem_gnt_i  = 1'b1;
        br_taken_i  = 1'b1;
        br_target_i = 32'h400;
        #1;
        checks++;
        if (if_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL branch_valid_kill: valid=%b want 0", if_valid_o);
        end
        step();
        br_taken_i = 1'b0;
        checks++;
        if (pc_o !== 32'h400 || misalign_o !== 1'b0) begin
            failures++;
            $display("FAIL branch_aligned: pc=%h mis=%b, want pc=00000400 mis=0", pc_o, misalign_o);
        end
        br_taken_i  = 1'b1;
        br_target_i = 32'h402;
        step();
        br_taken_i = 1'b0;
        checks++;
        if (pc_o !== 32'h400 || misalign_o !== 1'b1) begin
            failures++;
            $display("FAIL branch_misaligned: pc=%h mis=%b, want pc=00000400 mis=1", pc_o, misalign_o);
        end
        step();
        checks++;
        if (pc_o !== 32'h404 || misalign_o !== 1'b0) begin
            failures++;
            $display("FAIL misalign_one_pulse: pc=%h mis=%b, want pc=00000404 mis=0", pc_o, misalign_o);
        end
    endtask

    task automatic test_redirect_wait();
        imem_gnt_i  = 1'b0;
        br_taken_i  = 1'b1;
        br_target_i = 32'h200;
        step();
        br_taken_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h404 || if_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL redir_addr_hold[%0d]: req=%b addr=%h valid=%b, want req=1 addr=00000404 valid=0",
                         i, imem_req_o, imem_addr_o, if_valid_o);
            end
            step();
        end
        imem_gnt_i = 1'b1;
        #1;
        checks++;
        if (if_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL redir_discard: valid=%b want 0", if_valid_o);
        end
        step();
        checks++;
        if (pc_o !== 32'h200 || if_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL redir_apply: pc=%h valid=%b, want pc=00000200 valid=1", pc_o, if_valid_o);
        end
    endtask

    task automatic test_trap_priority();
        imem_gnt_i  = 1'b1;
        trap_i      = 1'b1;
        br_taken_i  = 1'b1;
        br_target_i = 32'h300;
        step();
        trap_i     = 1'b0;
        br_taken_i = 1'b0;
        checks++;
        if (pc_o !== 32'h100) begin
            failures++;
            $display("FAIL trap_beats_branch: pc=%h want 00000100", pc_o);
        end
        step();
        imem_gnt_i = 1'b0;
        trap_i     = 1'b1;
        step();
        trap_i      = 1'b0;
        br_taken_i  = 1'b1;
        br_target_i = 32'h500;
        step();
        br_taken_i = 1'b0;
        checks++;
        if (pc_o !== 32'h104 || imem_addr_o !== 32'h104 || misalign_o !== 1'b0) begin
            failures++;
            $display("FAIL trap_pending_hold: pc=%h addr=%h mis=%b, want pc=addr=00000104 mis=0",
                     pc_o, imem_addr_o, misalign_o);
        end
        imem_gnt_i = 1'b1;
        step();
        checks++;
        if (pc_o !== 32'h100) begin
            failures++;
            $display("FAIL trap_pending_kept: pc=%h want 00000100", pc_o);
        end
    endtask

    task automatic test_stall_wrap_reset();
        imem_gnt_i = 1'b1;
        stall_i    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (if_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_valid[%0d]: valid=%b want 0", i, if_valid_o);
            end
            step();
            checks++;
            if (pc_o !== 32'h100) begin
                failures++;
                $display("FAIL stall_hold[%0d]: pc=%h want 00000100", i, pc_o);
            end
        end
        stall_i = 1'b0;
        step();
        checks++;
        if (pc_o !== 32'h104) begin
            failures++;
            $display("FAIL stall_release: pc=%h want 00000104", pc_o);
        end
        br_taken_i  = 1'b1;
        br_target_i = 32'hFFFF_FFFC;
        step();
        br_taken_i = 1'b0;
        step();
        checks++;
        if (pc_o !== 32'h0) begin
            failures++;
            $display("FAIL pc_wrap: pc=%h want 00000000", pc_o);
        end
        step();
        imem_gnt_i  = 1'b0;
        br_taken_i  = 1'b1;
        br_target_i = 32'h800;
        step();
        br_taken_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || pc_o !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: req=%b pc=%h, want req=0 pc=0", imem_req_o, pc_o);
        end
        step();
        rst        = 1'b1;
        imem_gnt_i = 1'b1;
        step();
        step();
        checks++;
        if (pc_o !== 32'h4) begin
            failures++;
            $display("FAIL pending_lost: pc=%h want 00000004", pc_o);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_gnt_wait();
        test_branch();
        test_redirect_wait();
        test_trap_priority();
        test_stall_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
